fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage that consumes `hazard_data_t` from the hazard unit and produces the IF/ID pipeline register. Owns the architectural PC, drives the instruction bus with a valid/data_ok handshake, resolves branch direction for the `instfunc` redirect, and discards in-flight fetches made stale by a redirect. Sits between the hazard unit (upstream control) and decode (downstream consumer).

## Interface
Parameters:
- `PCINIT`, default `64'h8000_0000`: PC value after reset.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `dataH`  in  `hazard_data_t`  fields used: `pc_out`, `offset_out`, `instfunc`, `instr_FETCH`, `ireq_valid`, `reset_IF_ID`.
- `src1`, `src2`  in  64  branch comparison operands for the instruction in ID.
- `ireq`  out  `ibus_req_t`  `valid`, `addr` (64).
- `iresp`  in  `ibus_resp_t`  `data_ok`, `data` (32).
- `fd_pc`  out  64  PC of the instruction held in IF/ID.
- `fd_instr`  out  32  instruction held in IF/ID.
- `fd_bubble`  out  1  IF/ID holds no valid instruction.
- `Iwait`  out  1  fetch outstanding; the hazard unit treats it as a stall.

## Operation
- State machine: `IDLE` (no request), `REQ` (request outstanding), `KILL` (request outstanding, response to be discarded).
- `IDLE`→`REQ` when `dataH.ireq_valid`=1; `ireq.valid`=1, `ireq.addr`=pc.
- `REQ`: `ireq.valid` and `ireq.addr` stay constant until `iresp.data_ok`. On `data_ok`: load IF/ID (`fd_pc`=pc, `fd_instr`=data, `fd_bubble`=0), pc←pc+4, return to `IDLE`.
- Redirect resolution, evaluated each cycle from `dataH.instfunc`:
  - `PLUS4`: no redirect. `MAINTAIN`: no redirect, no new request, IF/ID held.
  - `JAL`: target = `pc_out + offset_out`. `JALR_P`: target = `offset_out`; it is already absolute with bit 0 clear.
  - `BEQ/BNE/BLT/BGE/BLTU/BGEU`: compare `src1` and `src2`, signed or unsigned per op. If taken, target = `pc_out + offset_out`. If not taken, no redirect.
- On redirect:
  - IF/ID is flushed (`fd_bubble`=1) and pc←target.
  - If in `REQ` without same-cycle `data_ok`: latch target in `pend_pc` and go to `KILL`.
  - In `KILL`, `data_ok` is consumed with no IF/ID write; pc←`pend_pc`; go to `IDLE`.
- `dataH.reset_IF_ID`=`RESET_RESET` forces `fd_bubble`=1 on the next edge. This overrides a same-cycle `data_ok` load.
- `dataH.instr_FETCH`=`INSTR_MAINTAIN` holds IF/ID. A `data_ok` arriving while held is parked in a one-entry buffer. While the buffer is full, no new request is issued.
- `Iwait` = (state≠`IDLE`) & ~`iresp.data_ok`.
- All adds are 64-bit and wrap modulo 2^64.

## Timing
- Reset values:
  - pc=`PCINIT`; state=`IDLE`.
  - `ireq.valid`=0, `ireq.addr`=`PCINIT`.
  - `fd_pc`=0, `fd_instr`=0, `fd_bubble`=1, `Iwait`=0, buffer empty.
- Minimum fetch latency: request issued in cycle N. If `data_ok` arrives in N, IF/ID is valid in N+1.
- Redirect and `data_ok` in the same cycle: the response is discarded, pc←target, next request issues in N+1.
- A second redirect while in `KILL` overwrites `pend_pc`.
- Reset asserted mid-request: `ireq.valid` drops immediately (asynchronous). A `data_ok` for the abandoned request after reset is ignored.

## Configuration
- `FETCH_ALIGN_CHECK_EN` defined:
  - A target with `addr[1:0]`≠0 is not requested.
  - IF/ID is loaded with `fd_bubble`=0, `fd_instr`=`32'h0000_0013` (nop), and an extra output `fd_misalign`=1.
  - The pc holds until the next redirect.
- Undefined: no check, `fd_misalign` absent; `addr` goes to the bus unmodified.

## Structure
- Add to `common` package:
  - `fetch_state_t` enum {IDLE, REQ, KILL}.
  - `PCINIT` constant.
  - `if_id_data_t` struct (pc, instr, bubble, misalign).
- Sub-module `branch_cmp`: combinational, takes (`instfunc`, `src1`, `src2`), outputs `taken`.
- Skid buffer and FSM live in `fetch_unit`.

## Test plan
- Reset, then `ireq_valid`=1, `data_ok` after 2 cycles with `data`=`0x00500093` -> `ireq.addr`=`0x80000000` stable 3 cycles; `fd_pc`=`0x80000000`, `fd_instr`=`0x00500093`, next `ireq.addr`=`0x80000004`.
- `BEQ`, `src1`=`src2`=5, `pc_out`=`0x80000010`, `offset_out`=`0x20` -> `fd_bubble`=1, next request addr `0x80000030`. `BLTU`, `src1`=1, `src2`=`-1` -> taken. `BLT` with the same operands -> not taken, no redirect.
- `JALR_P` with `offset_out`=`0x80001000` while in `REQ`; `data_ok` 3 cycles later -> that response is discarded, IF/ID bubble, next addr `0x80001000`.
- `instr_FETCH`=`MAINTAIN` for 4 cycles with `data_ok` in cycle 1 -> IF/ID unchanged, buffer holds the instruction, no request for 3 cycles, buffered instruction appears when released.
- `reset` pulsed while `ireq.valid`=1 -> `ireq.valid`=0 the same cycle, pc=`PCINIT`, late `data_ok` ignored.
- With `FETCH_ALIGN_CHECK_EN`: `JAL` target `0x80000102` -> no request, `fd_misalign`=1, `fd_instr`=`0x13`.

Source files
------------

// File: rtl/common_pkg.sv
// Shared pipeline types for the fetch stage: hazard-unit control bundle, instruction bus
// records, the IF/ID register layout and the fetch FSM state encoding.
package common;

    localparam logic [63:0] PCINIT    = 64'h8000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [3:0] {
        PLUS4, MAINTAIN, JAL, JALR_P, BEQ, BNE, BLT, BGE, BLTU, BGEU
    } instfunc_t;

    typedef enum logic {INSTR_NORMAL, INSTR_MAINTAIN} instr_fetch_t;
    typedef enum logic {RESET_NORMAL, RESET_RESET} reset_if_id_t;
    typedef enum logic [1:0] {IDLE, REQ, KILL} fetch_state_t;

    typedef struct packed {
        logic [63:0]  pc_out;
        logic [63:0]  offset_out;
        instfunc_t    instfunc;
        instr_fetch_t instr_FETCH;
        logic         ireq_valid;
        reset_if_id_t reset_IF_ID;
    } hazard_data_t;

    typedef struct packed {
        logic        valid;
        logic [63:0] addr;
    } ibus_req_t;

    typedef struct packed {
        logic        data_ok;
        logic [31:0] data;
    } ibus_resp_t;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
        logic        bubble;
        logic        misalign;
    } if_id_data_t;

    function automatic logic is_branch(input instfunc_t f);
        return f inside {BEQ, BNE, BLT, BGE, BLTU, BGEU};
    endfunction

endpackage

// File: rtl/fetch_unit_branch_cmp.sv
// Branch direction resolver: purely combinational compare of the ID-stage operands.
module branch_cmp
    import common::*;
(
    input  instfunc_t   instfunc,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    output logic        taken
);

    always_comb begin
        taken = 1'b0;
        case (instfunc)
            BEQ:     taken = (src1 == src2);
            BNE:     taken = (src1 != src2);
            BLT:     taken = ($signed(src1) <  $signed(src2));
            BGE:     taken = ($signed(src1) >= $signed(src2));
            BLTU:    taken = (src1 <  src2);
            BGEU:    taken = (src1 >= src2);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the ibus handshake and produces IF/ID.
// Optional alignment trap enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_unit
    import common::*;
#(
    parameter logic [63:0] PCINIT = common::PCINIT
) (
    input  logic         clk,
    input  logic         reset,
    input  hazard_data_t dataH,
    input  logic [63:0]  src1,
    input  logic [63:0]  src2,
    output ibus_req_t    ireq,
    input  ibus_resp_t   iresp,
    output logic [63:0]  fd_pc,
    output logic [31:0]  fd_instr,
    output logic         fd_bubble,
`ifdef FETCH_ALIGN_CHECK_EN
    output logic         fd_misalign,
`endif
    output logic         Iwait
);

    fetch_state_t state, state_next;
    logic [63:0]  pc, pc_next, pend_pc, target;
    logic         req_valid;
    logic [63:0]  req_addr;
    if_id_data_t  if_id, skid;
    logic         skid_valid;
    logic         taken, redirect, flush, hold, load_resp, busy_after;
    logic         skid_full_next, fetch_ok, issue;
`ifdef FETCH_ALIGN_CHECK_EN
    logic         mis_done, mis_load;
`endif

    branch_cmp u_branch_cmp (
        .instfunc (dataH.instfunc),
        .src1     (src1),
        .src2     (src2),
        .taken    (taken)
    );

    // Redirect target: JALR_P already arrives as an absolute, even address.
    always_comb begin
        redirect = 1'b0;
        target   = dataH.pc_out + dataH.offset_out;
        case (dataH.instfunc)
            JAL:     redirect = 1'b1;
            JALR_P: begin
                redirect = 1'b1;
                target   = dataH.offset_out;
            end
            default: redirect = is_branch(dataH.instfunc) & taken;
        endcase
    end

    // A new request may go out in the same cycle the previous one completes, but never
    // while the skid buffer will still be occupied after this edge.
    always_comb begin
        flush      = redirect | (dataH.reset_IF_ID == RESET_RESET);
        hold       = (dataH.instr_FETCH == INSTR_MAINTAIN) | (dataH.instfunc == MAINTAIN);
        load_resp  = (state == REQ) & iresp.data_ok & ~flush;
        busy_after = (state != IDLE) & ~iresp.data_ok;

        pc_next = pc;
        if (state == REQ && iresp.data_ok)
            pc_next = pc + 64'd4;
        if (state == KILL && iresp.data_ok)
            pc_next = pend_pc;
        if (redirect)
            pc_next = target;

        skid_full_next = ~flush & (skid_valid ? hold : (load_resp & hold));

        fetch_ok = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
        fetch_ok = (pc_next[1:0] == 2'b00);
`endif
        issue = ~busy_after & dataH.ireq_valid & (dataH.instfunc != MAINTAIN)
              & ~skid_full_next & fetch_ok;

`ifdef FETCH_ALIGN_CHECK_EN
        mis_load = ~busy_after & dataH.ireq_valid & (dataH.instfunc != MAINTAIN) & ~fetch_ok
                 & ~mis_done & ~flush & ~hold & ~skid_valid;
`endif

        if (busy_after)
            state_next = redirect ? KILL : state;
        else
            state_next = issue ? REQ : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pc        <= PCINIT;
            pend_pc   <= PCINIT;
            req_valid <= 1'b0;
            req_addr  <= PCINIT;
        end else begin
            state     <= state_next;
            pc        <= pc_next;
            req_valid <= (state_next != IDLE);
            if (redirect)
                pend_pc <= target;
            if (issue)
                req_addr <= pc_next;
        end
    end

    // IF/ID and skid buffer: a held stage parks the arriving word and replays it on release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id      <= '{pc: 64'd0, instr: 32'd0, bubble: 1'b1, misalign: 1'b0};
            skid       <= '0;
            skid_valid <= 1'b0;
`ifdef FETCH_ALIGN_CHECK_EN
            mis_done   <= 1'b0;
`endif
        end else begin
            if (flush) begin
                if_id.bubble   <= 1'b1;
                if_id.misalign <= 1'b0;
                skid_valid     <= 1'b0;
            end else if (hold) begin
                if (load_resp) begin
                    skid       <= '{pc: pc, instr: iresp.data, bubble: 1'b0, misalign: 1'b0};
                    skid_valid <= 1'b1;
                end
            end else if (skid_valid) begin
                if_id      <= skid;
                skid_valid <= 1'b0;
            end else if (load_resp) begin
                if_id <= '{pc: pc, instr: iresp.data, bubble: 1'b0, misalign: 1'b0};
`ifdef FETCH_ALIGN_CHECK_EN
            end else if (mis_load) begin
                if_id <= '{pc: pc_next, instr: NOP_INSTR, bubble: 1'b0, misalign: 1'b1};
`endif
            end else begin
                if_id.bubble   <= 1'b1;
                if_id.misalign <= 1'b0;
            end
`ifdef FETCH_ALIGN_CHECK_EN
            if (redirect)
                mis_done <= 1'b0;
            else if (mis_load)
                mis_done <= 1'b1;
`endif
        end
    end

    assign ireq.valid = req_valid;
    assign ireq.addr  = req_addr;
    assign fd_pc      = if_id.pc;
    assign fd_instr   = if_id.instr;
    assign fd_bubble  = if_id.bubble;
    assign Iwait      = (state != IDLE) & ~iresp.data_ok;

`ifdef FETCH_ALIGN_CHECK_EN
    assign fd_misalign = if_id.misalign;
`else
    logic unused_misalign;
    assign unused_misalign = if_id.misalign;
`endif

endmodule
